tx_phy_framer: RTL

- Physical-layer transmit framer that sits directly downstream of the TX data link layer.
- Accepts complete 1024-bit LCRC-protected TLPs from the data link layer, plus 32-bit outgoing DLLPs (ACK/NAK/FC from the RX side).
- Arbitrates between the two sources at frame boundaries, then serializes the winner onto a narrower PHY bus as sop/eop-delimited beats under a valid/ready handshake.

---
 rtl/tx_phy_framer.sv | 119 +++++++++++
 1 files changed

// File: rtl/tx_phy_framer.sv
// Transmit PHY framer: arbitrates whole TLPs against DLLPs at frame boundaries
// and serializes the winner onto the PHY bus as sop/eop-delimited beats.
module tx_phy_framer #(
    parameter int unsigned DATA_W       = 1024,
    parameter int unsigned PHY_W        = 128,
    parameter int unsigned DLLP_W       = 32,
    parameter int unsigned MAX_DLLP_RUN = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] tlp_data_in,
    input  logic              tlp_data_in_valid,
    output logic              tlp_data_in_ready,
    input  logic [DLLP_W-1:0] dllp_data_in,
    input  logic              dllp_data_in_valid,
    output logic              dllp_data_in_ready,
    output logic [PHY_W-1:0]  phy_data_out,
    output logic              phy_data_out_valid,
    input  logic              phy_data_out_ready,
    output logic              phy_sop,
    output logic              phy_eop,
    output logic              phy_kind
);

    localparam int unsigned BEATS = DATA_W / PHY_W;
    localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned RUN_W = (MAX_DLLP_RUN > 0) ? $clog2(MAX_DLLP_RUN + 1) : 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND_TLP  = 2'd1,
        SEND_DLLP = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [DATA_W-1:0]  shift, shift_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [RUN_W-1:0]   dllp_run, dllp_run_nxt;
    logic               grant_dllp, grant_tlp;

    // State register; a DLLP is parked in the low bits of the shift register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            shift    <= '0;
            cnt      <= '0;
            dllp_run <= '0;
        end else begin
            state    <= state_nxt;
            shift    <= shift_nxt;
            cnt      <= cnt_nxt;
            dllp_run <= dllp_run_nxt;
        end
    end

    // Arbitration, next-state and beat outputs; PHY outputs depend only on flops.
    always_comb begin
        state_nxt          = state;
        shift_nxt          = shift;
        cnt_nxt            = cnt;
        dllp_run_nxt       = dllp_run;
        tlp_data_in_ready  = 1'b0;
        dllp_data_in_ready = 1'b0;
        phy_data_out       = '0;
        phy_data_out_valid = 1'b0;
        phy_sop            = 1'b0;
        phy_eop            = 1'b0;
        phy_kind           = 1'b0;

        // A waiting TLP wins once MAX_DLLP_RUN DLLPs have gone ahead of it.
        grant_dllp = dllp_data_in_valid &&
                     !(tlp_data_in_valid && (dllp_run == RUN_W'(MAX_DLLP_RUN)));
        grant_tlp  = tlp_data_in_valid && !grant_dllp;

        case (state)
            IDLE: begin
                dllp_data_in_ready = reset_n && grant_dllp;
                tlp_data_in_ready  = reset_n && grant_tlp;
                if (grant_dllp) begin
                    shift_nxt    = DATA_W'(dllp_data_in);
                    dllp_run_nxt = tlp_data_in_valid ? dllp_run + RUN_W'(1) : '0;
                    state_nxt    = SEND_DLLP;
                end else if (grant_tlp) begin
                    shift_nxt    = tlp_data_in;
                    cnt_nxt      = '0;
                    dllp_run_nxt = '0;
                    state_nxt    = SEND_TLP;
                end
            end
            SEND_TLP: begin
                phy_data_out       = shift[PHY_W-1:0];
                phy_data_out_valid = 1'b1;
                phy_sop            = (cnt == '0);
                phy_eop            = (cnt == CNT_W'(BEATS - 1));
                if (phy_data_out_ready) begin
                    shift_nxt = shift >> PHY_W;
                    cnt_nxt   = cnt + CNT_W'(1);
                    if (phy_eop) begin
                        state_nxt = IDLE;
                    end
                end
            end
            SEND_DLLP: begin
                phy_data_out       = shift[PHY_W-1:0];
                phy_data_out_valid = 1'b1;
                phy_sop            = 1'b1;
                phy_eop            = 1'b1;
                phy_kind           = 1'b1;
                if (phy_data_out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
